// File: rtl/nes_bus_pkg.sv
// Shared definitions for the CPU bus responder: region and DMA state
// encodings, region base addresses, the OAMDATA register index, and the
// address decode helper used for both CPU accesses and DMA fetches.
package nes_bus_pkg;

    typedef enum logic [2:0] {
        REG_RAM  = 3'd0,
        REG_PPU  = 3'd1,
        REG_IO   = 3'd2,
        REG_NONE = 3'd3,
        REG_PRG  = 3'd4
    } region_e;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_ALIGN = 2'd1,
        DMA_RD    = 2'd2,
        DMA_WR    = 2'd3
    } dma_state_e;

    localparam logic [15:0] PPU_BASE  = 16'h2000;
    localparam logic [15:0] IO_BASE   = 16'h4000;
    localparam logic [15:0] NONE_BASE = 16'h4020;
    localparam logic [15:0] PRG_BASE  = 16'h8000;

    localparam logic [2:0] OAMDATA_IDX = 3'd4;

    function automatic region_e decode_region(input logic [15:0] a);
        region_e r;
        if (a < PPU_BASE)       r = REG_RAM;
        else if (a < IO_BASE)   r = REG_PPU;
        else if (a < NONE_BASE) r = REG_IO;
        else if (a < PRG_BASE)  r = REG_NONE;
        else                    r = REG_PRG;
        return r;
    endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine: copies 256 bytes from page {page_i,xx} into PPU OAMDATA.
// Latency: rdy_o drops the cycle after trig_i; 1 align + 256 x (read, write) = 513 stall cycles.
// Backpressure: none accepted; stalls the CPU through rdy_o while busy, trig_i ignored unless idle.
// Ports: trig_i/page_i start a transfer; rd_o/rd_addr_o request a fetch whose result
// arrives on fetch_dat_i in the same cycle; ppu_we_o/ppu_wdata_o write OAMDATA.
// Only built when OAM_DMA_EN is defined.
`ifdef OAM_DMA_EN
module oam_dma_ctrl
    import nes_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trig_i,
    input  logic [7:0]  page_i,
    input  logic [7:0]  fetch_dat_i,
    output logic        rdy_o,
    output logic        rd_o,
    output logic [15:0] rd_addr_o,
    output logic        ppu_we_o,
    output logic [7:0]  ppu_wdata_o
);

    dma_state_e state_q, state_d;
    logic [7:0] page_q;
    logic [7:0] cnt_q;
    logic [7:0] dma_byte_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DMA_IDLE;
            page_q     <= 8'h00;
            cnt_q      <= 8'h00;
            dma_byte_q <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_q == DMA_IDLE && trig_i) begin
                page_q <= page_i;
                cnt_q  <= 8'h00;
            end
            if (state_q == DMA_RD) dma_byte_q <= fetch_dat_i;
            // Wraps FF->00 on the final write, leaving the counter clean for the next run.
            if (state_q == DMA_WR) cnt_q <= cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        rdy_o    = 1'b0;
        rd_o     = 1'b0;
        ppu_we_o = 1'b0;
        case (state_q)
            DMA_IDLE: begin
                rdy_o = 1'b1;
                if (trig_i) state_d = DMA_ALIGN;
            end
            DMA_ALIGN: state_d = DMA_RD;
            DMA_RD: begin
                rd_o    = 1'b1;
                state_d = DMA_WR;
            end
            DMA_WR: begin
                ppu_we_o = 1'b1;
                state_d  = (cnt_q == 8'hFF) ? DMA_IDLE : DMA_RD;
            end
            default: state_d = DMA_IDLE;
        endcase
    end

    assign rd_addr_o   = {page_q, cnt_q};
    assign ppu_wdata_o = dma_byte_q;

endmodule
`endif

// File: rtl/cpu_bus_responder.sv
// Target side of the 6502 bus: decodes RAM/PPU/IO/PRG, answers reads, hosts OAM DMA.
// Latency: read sampled at posedge N+1 is driven on data from N+1 until N+2; writes take effect at the sampling edge.
// Backpressure: rdy low holds the CPU for the 513-cycle OAM DMA; otherwise always ready.
// Ports: addr/data/rw_n CPU bus, rdy stall; ppu_* and io_* register windows with
// single-cycle strobes; prg_addr/prg_rdata combinational ROM port.
// Build option OAM_DMA_EN: enables the DMA engine at DMA_REG_ADDR; without it rdy
// stays 1 and that address is an ordinary IO register.
module cpu_bus_responder
    import nes_bus_pkg::*;
#(
    parameter int          RAM_AW       = 11,
    parameter int          PRG_AW       = 15,
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       addr,
    inout  wire  [7:0]        data,
    input  logic              rw_n,
    output logic              rdy,
    output logic [2:0]        ppu_reg,
    output logic              ppu_we,
    output logic              ppu_re,
    output logic [7:0]        ppu_wdata,
    input  logic [7:0]        ppu_rdata,
    output logic [4:0]        io_addr,
    output logic              io_we,
    output logic              io_re,
    output logic [7:0]        io_wdata,
    input  logic [7:0]        io_rdata,
    output logic [PRG_AW-1:0] prg_addr,
    input  logic [7:0]        prg_rdata
);

    logic [7:0] ram_q [2**RAM_AW];
    logic       bus_en_q;
    logic       drive_q;
    logic [7:0] rdata_q;
    logic [7:0] last_bus_q;

    logic        dma_hit, dma_rd, dma_we, dma_rdy;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;

    // bus_en_q keeps every combinational strobe at zero from reset assertion
    // until the first clock edge after release.
    logic    cpu_act, cpu_rd, cpu_wr, cpu_ppu_we;
    region_e cpu_reg, eff_reg;
    logic [15:0] eff_addr;
    logic [7:0]  sel_byte;

    assign cpu_act = bus_en_q & dma_rdy;
    assign cpu_rd  = cpu_act & rw_n;
    assign cpu_wr  = cpu_act & ~rw_n;
    assign cpu_reg = decode_region(addr);

`ifdef OAM_DMA_EN
    assign dma_hit = cpu_wr && (addr == DMA_REG_ADDR);

    oam_dma_ctrl u_dma (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig_i      (dma_hit),
        .page_i      (data),
        .fetch_dat_i (sel_byte),
        .rdy_o       (dma_rdy),
        .rd_o        (dma_rd),
        .rd_addr_o   (dma_addr),
        .ppu_we_o    (dma_we),
        .ppu_wdata_o (dma_wdata)
    );
`else
    assign dma_hit   = 1'b0;
    assign dma_rd    = 1'b0;
    assign dma_we    = 1'b0;
    assign dma_rdy   = 1'b1;
    assign dma_addr  = 16'h0000;
    assign dma_wdata = 8'h00;
`endif

    // DMA fetches share the CPU decode path so RAM mirroring and PRG access behave identically.
    assign eff_addr = dma_rd ? dma_addr : addr;
    assign eff_reg  = decode_region(eff_addr);
    assign prg_addr = eff_addr[PRG_AW-1:0];

    always_comb begin
        sel_byte = last_bus_q;
        case (eff_reg)
            REG_RAM: sel_byte = ram_q[eff_addr[RAM_AW-1:0]];
            // DMA must not trigger register side effects, so it sees open bus here.
            REG_PPU: sel_byte = dma_rd ? last_bus_q : ppu_rdata;
            REG_IO:  sel_byte = dma_rd ? last_bus_q : io_rdata;
            REG_PRG: sel_byte = prg_rdata;
            default: sel_byte = last_bus_q;
        endcase
    end

    assign ppu_re     = cpu_rd && (cpu_reg == REG_PPU);
    assign io_re      = cpu_rd && (cpu_reg == REG_IO);
    assign cpu_ppu_we = cpu_wr && (cpu_reg == REG_PPU);
    assign io_we      = cpu_wr && (cpu_reg == REG_IO) && !dma_hit;
    assign ppu_we     = cpu_ppu_we | dma_we;
    assign ppu_reg    = !dma_rdy ? OAMDATA_IDX : (cpu_act ? addr[2:0] : 3'd0);
    assign io_addr    = cpu_act ? addr[4:0] : 5'd0;
    assign ppu_wdata  = dma_we ? dma_wdata : (cpu_ppu_we ? data : 8'h00);
    assign io_wdata   = io_we ? data : 8'h00;
    assign rdy        = dma_rdy;

    // A CPU write in the response cycle owns the bus; the stale response is dropped.
    assign data = (drive_q && !cpu_wr) ? rdata_q : 8'hzz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_en_q   <= 1'b0;
            drive_q    <= 1'b0;
            rdata_q    <= 8'h00;
            last_bus_q <= 8'h00;
        end else begin
            bus_en_q <= 1'b1;
            drive_q  <= cpu_rd;
            if (cpu_rd) begin
                rdata_q    <= sel_byte;
                last_bus_q <= sel_byte;
            end else if (cpu_wr) begin
                last_bus_q <= data;
            end
        end
    end

    // Work RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (cpu_wr && (cpu_reg == REG_RAM)) ram_q[addr[RAM_AW-1:0]] <= data;
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
module tb_cpu_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr;
    wire  [7:0]  data;
    logic        rw_n;
    logic        rdy;
    logic [2:0]  ppu_reg;
    logic        ppu_we, ppu_re;
    logic [7:0]  ppu_wdata, ppu_rdata;
    logic [4:0]  io_addr;
    logic        io_we, io_re;
    logic [7:0]  io_wdata, io_rdata;
    logic [14:0] prg_addr;
    logic [7:0]  prg_rdata;

    logic       tb_drv;
    logic [7:0] tb_dat;
    assign data = tb_drv ? tb_dat : 8'hzz;

    always #5 clk = ~clk;

    cpu_bus_responder dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data(data), .rw_n(rw_n), .rdy(rdy),
        .ppu_reg(ppu_reg), .ppu_we(ppu_we), .ppu_re(ppu_re), .ppu_wdata(ppu_wdata),
        .ppu_rdata(ppu_rdata), .io_addr(io_addr), .io_we(io_we), .io_re(io_re),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .prg_addr(prg_addr), .prg_rdata(prg_rdata)
    );

    // PRG ROM contents: a fixed function of the ROM address.
    function automatic logic [7:0] rom_f(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
    endfunction
    assign prg_rdata = rom_f(prg_addr);

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    logic [7:0] ram_m [2048];
    logic [7:0] last_m = 8'h00;

    typedef struct {
        int         due;
        logic [7:0] val;
    } dexp_t;
    typedef struct {
        int         due;
        bit         pre, pwe, ire, iwe, wr;
        logic [2:0] preg;
        logic [4:0] iaddr;
        logic [7:0] wd;
    } sexp_t;
    dexp_t dq[$];
    sexp_t sq[$];

    // One CPU bus cycle: present the access, record what the DUT must do, advance a clock.
    task automatic cpu_cycle(input logic [15:0] a, input bit wr, input logic [7:0] wd, input int prd);
        sexp_t      s;
        dexp_t      d;
        logic [7:0] v;
        addr      = a;
        rw_n      = !wr;
        tb_drv    = wr;
        tb_dat    = wd;
        ppu_rdata = (prd < 0) ? 8'($urandom) : 8'(prd);
        io_rdata  = 8'($urandom);
        s.due = cyc; s.pre = 0; s.pwe = 0; s.ire = 0; s.iwe = 0; s.wr = wr;
        s.preg = 3'd0; s.iaddr = 5'd0; s.wd = wd;
        if (wr) begin
            if (a < 16'h2000) ram_m[a[10:0]] = wd;
            else if (a < 16'h4000) begin s.pwe = 1; s.preg = a[2:0]; end
            else if (a < 16'h4020) begin
`ifdef OAM_DMA_EN
                if (a != 16'h4014)
`endif
                begin s.iwe = 1; s.iaddr = a[4:0]; end
            end
            last_m = wd;
            if (dq.size() > 0 && dq[$].due == cyc) void'(dq.pop_back());
        end else begin
            if (a < 16'h2000)      v = ram_m[a[10:0]];
            else if (a < 16'h4000) begin v = ppu_rdata; s.pre = 1; s.preg = a[2:0]; end
            else if (a < 16'h4020) begin v = io_rdata; s.ire = 1; s.iaddr = a[4:0]; end
            else if (a < 16'h8000) v = last_m;
            else                   v = rom_f(a[14:0]);
            last_m = v;
            d.due = cyc + 1;
            d.val = v;
            dq.push_back(d);
        end
        sq.push_back(s);
        @(posedge clk); #1;
    endtask

    // Monitor: compares DUT outputs against queued expectations when they fall due.
    always @(negedge clk) begin
        sexp_t s;
        dexp_t d;
        while (sq.size() > 0 && sq[0].due < cyc) begin
            s = sq.pop_front();
            chk("strobe_missed", 32'(s.due), 32'(cyc));
        end
        while (dq.size() > 0 && dq[0].due < cyc) begin
            d = dq.pop_front();
            chk("rdata_missed", 32'(d.due), 32'(cyc));
        end
        if (sq.size() > 0 && sq[0].due == cyc) begin
            s = sq.pop_front();
            chk("ppu_re", 32'(ppu_re), 32'(s.pre));
            chk("ppu_we", 32'(ppu_we), 32'(s.pwe));
            chk("io_re", 32'(io_re), 32'(s.ire));
            chk("io_we", 32'(io_we), 32'(s.iwe));
            if (s.pre || s.pwe) chk("ppu_reg", 32'(ppu_reg), 32'(s.preg));
            if (s.pwe) chk("ppu_wdata", 32'(ppu_wdata), 32'(s.wd));
            if (s.ire || s.iwe) chk("io_addr", 32'(io_addr), 32'(s.iaddr));
            if (s.iwe) chk("io_wdata", 32'(io_wdata), 32'(s.wd));
            if (s.wr) chk("bus_during_write", 32'(data), 32'(s.wd));
        end
        if (dq.size() > 0 && dq[0].due == cyc) begin
            d = dq.pop_front();
            chk("read_data", 32'(data), 32'(d.val));
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_rdy"}, 32'(rdy), 32'd1);
        chk({tag, "_ppu_re"}, 32'(ppu_re), 32'd0);
        chk({tag, "_ppu_we"}, 32'(ppu_we), 32'd0);
        chk({tag, "_io_re"}, 32'(io_re), 32'd0);
        chk({tag, "_io_we"}, 32'(io_we), 32'd0);
        chk({tag, "_ppu_reg"}, 32'(ppu_reg), 32'd0);
        chk({tag, "_io_addr"}, 32'(io_addr), 32'd0);
        chk({tag, "_ppu_wdata"}, 32'(ppu_wdata), 32'd0);
        chk({tag, "_io_wdata"}, 32'(io_wdata), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        int          stall, guard, nwe, bad_reg, bad_cpu;
        logic [7:0]  got[$];

        addr = 16'h2002; rw_n = 1'b1; tb_drv = 1'b0; tb_dat = 8'h00;
        ppu_rdata = 8'h00; io_rdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Preload the low RAM page used by the random phase.
        for (int i = 0; i < 64; i++) cpu_cycle(16'(i), 1'b1, 8'($urandom), -1);

        // Mirror read, PPU read strobe, open bus after a RAM read.
        cpu_cycle(16'h0005, 1'b1, 8'h2A, -1);
        cpu_cycle(16'h0805, 1'b0, 8'h00, -1);
        cpu_cycle(16'h2002, 1'b0, 8'h00, 8'h80);
        cpu_cycle(16'h8123, 1'b0, 8'h00, -1);
        cpu_cycle(16'h0010, 1'b1, 8'h3C, -1);
        cpu_cycle(16'h0010, 1'b0, 8'h00, -1);
        cpu_cycle(16'h5000, 1'b0, 8'h00, -1);

        // Randomised traffic across all windows.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0: a = 16'(($urandom_range(0, 3) << 11) | $urandom_range(0, 63));
                1: a = 16'(16'h2000 + $urandom_range(0, 16'h1FFF));
                2: begin
                    a = 16'(16'h4000 + $urandom_range(0, 31));
                    if (a == 16'h4014) a = 16'h4015;
                end
                3: a = 16'(16'h4020 + $urandom_range(0, 16'h3FDF));
                default: a = 16'(16'h8000 + $urandom_range(0, 16'h7FFF));
            endcase
            cpu_cycle(a, ($urandom_range(0, 2) == 0), 8'($urandom), -1);
        end

`ifdef OAM_DMA_EN
        for (int i = 0; i < 256; i++) cpu_cycle(16'(16'h0200 + i), 1'b1, 8'(i) ^ 8'h55, -1);
        cpu_cycle(16'h4014, 1'b1, 8'h02, -1);
        chk("dma_rdy_low", 32'(rdy), 32'd0);
        addr = 16'h2002; rw_n = 1'b1; tb_drv = 1'b0;
        stall = 0; bad_reg = 0; bad_cpu = 0;
        while (rdy == 1'b0 && stall < 600) begin
            stall++;
            if (ppu_re || io_re || io_we) bad_cpu++;
            if (ppu_we) begin
                if (ppu_reg != 3'd4) bad_reg++;
                got.push_back(ppu_wdata);
            end
            @(posedge clk); #1;
        end
        chk("dma_stall_cycles", 32'(stall), 32'd513);
        chk("dma_write_count", 32'(got.size()), 32'd256);
        chk("dma_ppu_reg", 32'(bad_reg), 32'd0);
        chk("dma_cpu_strobes", 32'(bad_cpu), 32'd0);
        for (int i = 0; i < got.size() && i < 256; i++)
            chk("dma_byte", 32'(got[i]), 32'(8'(i) ^ 8'h55));
        chk("dma_rdy_after", 32'(rdy), 32'd1);
        // The held access is serviced once rdy returns.
        cpu_cycle(16'h2002, 1'b0, 8'h00, -1);
        cpu_cycle(16'h0805, 1'b0, 8'h00, -1);

        // Second transfer, interrupted by reset at byte 100.
        cpu_cycle(16'h4014, 1'b1, 8'h02, -1);
        addr = 16'h0005; rw_n = 1'b1; tb_drv = 1'b0;
        nwe = 0; guard = 0;
        while (nwe < 100 && guard < 600) begin
            if (ppu_we) nwe++;
            guard++;
            @(posedge clk); #1;
        end
        chk("dma_reached_byte100", 32'(nwe), 32'd100);
`else
        cpu_cycle(16'h4014, 1'b1, 8'h07, -1);
        chk("rdy_no_dma", 32'(rdy), 32'd1);
        cpu_cycle(16'h0805, 1'b0, 8'h00, -1);
        chk("rdy_no_dma_after", 32'(rdy), 32'd1);
        addr = 16'h2002; rw_n = 1'b1; tb_drv = 1'b0;
`endif

        rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        dq.delete();
        sq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_checks("midrst_hold");
        rst_n = 1'b1;
        last_m = 8'h00;
        @(posedge clk); #1;

        // Open bus is cleared by reset; RAM is not; no DMA writes resume.
        cpu_cycle(16'h5000, 1'b0, 8'h00, -1);
        for (int i = 0; i < 330; i++) cpu_cycle(16'h0005, 1'b0, 8'h00, -1);
        cpu_cycle(16'h6ABC, 1'b0, 8'h00, -1);

        repeat (2) @(posedge clk);
        #1;
        chk("queues_drained", 32'(dq.size() + sq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Target side of the cpu_6502 memory bus; the CPU is the initiator (addr, data, rw_n).
- Decodes every CPU access into four targets:
  - 2 KB internal work RAM
  - PPU register window
  - APU/IO window
  - cartridge PRG ROM
- Services reads with fixed one-cycle latency and drives the shared data bus.
- Contains the OAM DMA engine, which stalls the CPU through rdy.

Parameters:
- RAM_AW, 11, work RAM address width (2^RAM_AW bytes, mirrored across $0000-$1FFF).
- PRG_AW, 15, PRG ROM address width (mirrored across $8000-$FFFF).
- DMA_REG_ADDR, 16'h4014, CPU address of the OAM DMA trigger register.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- addr  in  16  CPU address, registered by the CPU on posedge clk
- data  inout  8  shared CPU data bus
- rw_n  in  1  1 = read, 0 = write
- rdy  out  1  1 = CPU may proceed; 0 = CPU must hold (DMA active)
- ppu_reg  out  3  PPU register index (addr[2:0], or 3'd4 during DMA)
- ppu_we  out  1  one-cycle PPU register write strobe
- ppu_re  out  1  one-cycle PPU register read strobe
- ppu_wdata  out  8  PPU write data
- ppu_rdata  in  8  PPU read data, valid in the cycle ppu_re is high
- io_addr  out  5  APU/IO register index (addr[4:0])
- io_we  out  1  APU/IO write strobe
- io_re  out  1  APU/IO read strobe
- io_wdata  out  8  APU/IO write data
- io_rdata  in  8  APU/IO read data, valid with io_re
- prg_addr  out  PRG_AW  PRG ROM address
- prg_rdata  in  8  PRG ROM data, combinational from prg_addr

Behaviour:
- Address decode (from bits of addr):
  - $0000-$1FFF: RAM, index addr[RAM_AW-1:0].
  - $2000-$3FFF: PPU, ppu_reg = addr[2:0].
  - $4000-$401F: IO.
  - $4020-$7FFF: unmapped.
  - $8000-$FFFF: PRG, prg_addr = addr[PRG_AW-1:0].
- Read timing (rw_n=1):
  - At posedge N+1 the block samples the addr presented since posedge N.
  - The selected byte is registered into rdata_q and drive_q is set to 1.
  - data = rdata_q while drive_q=1, otherwise high-Z. The CPU captures it at posedge N+2.
- Strobes:
  - ppu_re and io_re pulse in the sampling cycle only.
  - Reads of the PPU and IO windows are not repeated while the address is stable, because the CPU issues a new address every cycle.
- Unmapped reads return open bus: last_bus_q, the most recent byte driven or written on data.
- Write timing (rw_n=0), at posedge:
  - RAM write, or one-cycle ppu_we/io_we pulse with wdata = data.
  - drive_q = 0, so the block never drives the bus during CPU writes.
  - Writes to PRG and unmapped space are ignored.
- last_bus_q updates on every read response and every write.
- DMA FSM states: IDLE, ALIGN, RD, WR.
  - IDLE->ALIGN: CPU write to DMA_REG_ADDR; page_q = data, cnt_q = 0, rdy = 0 from the next cycle.
  - ALIGN->RD: after 1 cycle.
  - RD: fetch byte at {page_q, cnt_q} through the same decode (RAM/PRG/open bus; PPU/IO pages return open bus, no strobes); latch into dma_byte_q; go to WR.
  - WR: ppu_reg = 4, ppu_wdata = dma_byte_q, ppu_we = 1; cnt_q += 1.
  - WR->RD: if cnt_q != 8'hFF.
  - WR->IDLE: if cnt_q == 8'hFF, rdy = 1 in the cycle after the last WR.
  - Total stall: 1 + 256*2 = 513 cycles.
- During DMA:
  - CPU bus inputs are ignored.
  - drive_q = 0.
  - cnt_q wrap 8'hFF->8'h00 ends the transfer.
- A second write to DMA_REG_ADDR is impossible while rdy=0; if it occurs it is ignored.
- Reset (async, rst_n=0), including mid-DMA:
  - FSM = IDLE, rdy = 1.
  - drive_q = 0, data released to high-Z.
  - All strobes = 0, ppu_reg = 0, io_addr = 0, ppu_wdata = io_wdata = 0.
  - last_bus_q = 0, cnt_q = 0, page_q = 0.
  - RAM contents are not reset.

Optional Feature:
- OAM_DMA_EN:
  - Defined: DMA FSM as above.
  - Undefined: no FSM, rdy tied to 1, and a write to DMA_REG_ADDR is a plain IO write (io_we, io_addr = 5'h14).

Decomposition:
- Package nes_bus_pkg holds:
  - region encoding enum (REG_RAM, REG_PPU, REG_IO, REG_NONE, REG_PRG)
  - DMA state enum
  - region base constants
  - OAMDATA index 3'd4
- Sub-module oam_dma_ctrl (FSM, page/count, ppu write outputs) sits under the OAM_DMA_EN guard.
- Decode and RAM stay in the top level.

Test Plan:
- Write $2A to $0005, then read $0805 -> data = $2A one cycle after sampling (mirror); data high-Z during the write.
- Read $2002 with ppu_rdata = $80 -> single ppu_re pulse with ppu_reg = 2; data = $80 next cycle.
- Read $5000 right after a read that returned $3C -> data = $3C (open bus); no strobes.
- Fill RAM $0200-$02FF with i^$55, write $02 to $4014 -> rdy low for exactly 513 cycles; 256 ppu_we pulses with ppu_reg = 4 and data i^$55 in order; rdy = 1 afterwards.
- Assert rst_n = 0 at DMA byte 100 -> rdy = 1 and strobes 0 immediately; no further ppu_we after release.
- Build without OAM_DMA_EN, write $07 to $4014 -> io_we with io_addr = $14 and io_wdata = $07; rdy stays 1.
